// File: rtl/axi4_bridge_pkg.sv
// Shared types and helpers for the AXI4-Stream to AXI4 burst writer.
// Holds the FSM encoding, AXI4 burst constants and the 4 KB / 256-beat length clamp.
package axi4_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_e;

  localparam logic [1:0]  BURST_INCR     = 2'b01;
  localparam int unsigned AXI4_MAX_BEATS = 256;

  // Beats in the next burst (1..256): limited by the packet remainder and the next 4 KB page.
  function automatic logic [8:0] calc_burst_len(input logic [31:0] beats_left,
                                                input logic [11:0] addr_lo,
                                                input logic [3:0]  size_log2);
    logic [12:0] to_4k;
    logic [8:0]  len;
    to_4k = (13'd4096 - {1'b0, addr_lo}) >> size_log2;
    len   = 9'(AXI4_MAX_BEATS);
    if (to_4k < 13'(len)) len = to_4k[8:0];
    if (beats_left < 32'(len)) len = beats_left[8:0];
    return len;
  endfunction

endpackage

// File: rtl/axis_to_axi4_burst_writer.sv
// Writes one stream packet to memory as legal AXI4 INCR bursts; AW one cycle after first tvalid,
// W is a zero-latency passthrough so stream backpressure is wready, and only one burst is outstanding.
module axis_to_axi4_burst_writer
  import axi4_bridge_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 64,
  parameter  int unsigned ADDR_WIDTH     = 32,
  parameter  int unsigned MAX_PKT_SIZE_B = 9600,
  localparam int unsigned SIZE_W         = $clog2(MAX_PKT_SIZE_B + 1),
  localparam int unsigned BYTES          = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SIZE_W-1:0]     pkt_size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] pkt_tdata_i,
  input  logic [BYTES-1:0]      pkt_tkeep_i,
  input  logic                  pkt_tvalid_i,
  input  logic                  pkt_tlast_i,
  output logic                  pkt_tready_o,
  output logic [ADDR_WIDTH-1:0] mem_awaddr_o,
  output logic [7:0]            mem_awlen_o,
  output logic [2:0]            mem_awsize_o,
  output logic [1:0]            mem_awburst_o,
  output logic [3:0]            mem_awid_o,
  output logic                  mem_awlock_o,
  output logic [3:0]            mem_awcache_o,
  output logic [2:0]            mem_awprot_o,
  output logic [3:0]            mem_awqos_o,
  output logic                  mem_awvalid_o,
  input  logic                  mem_awready_i,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BYTES-1:0]      mem_wstrb_o,
  output logic                  mem_wlast_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  input  logic [1:0]            mem_bresp_i,
  input  logic                  mem_bvalid_i,
  output logic                  mem_bready_o,
  output logic                  mem_arvalid_o,
  output logic                  mem_rready_o
);

  localparam int unsigned SIZE_LOG2 = $clog2(BYTES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE_W-1:0]     beats_left_q, beats_left_d;
  logic [SIZE_LOG2-1:0]  rem_q, rem_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;

  logic [SIZE_W:0]       size_rnd;
  logic [SIZE_W-1:0]     beats_in;
  logic [8:0]            len_now;
  logic [BYTES-1:0]      strb_last;
  logic                  burst_end;
  logic                  unused_ok;

  assign size_rnd  = {1'b0, pkt_size_i} + (SIZE_W + 1)'(BYTES - 1);
  assign beats_in  = SIZE_W'(size_rnd >> SIZE_LOG2);
  assign len_now   = calc_burst_len(32'(beats_left_q), cur_addr_q[11:0], 4'(SIZE_LOG2));
  assign strb_last = ~({BYTES{1'b1}} << rem_q);
  assign burst_end = (beat_cnt_q == len_q - 9'd1);

  // AW fields come straight from registers that cannot change while in ADDR.
  assign mem_awaddr_o  = cur_addr_q;
  assign mem_awlen_o   = 8'(len_now - 9'd1);
  assign mem_awsize_o  = 3'(SIZE_LOG2);
  assign mem_awburst_o = BURST_INCR;
  assign mem_awid_o    = '0;
  assign mem_awlock_o  = 1'b0;
  assign mem_awcache_o = '0;
  assign mem_awprot_o  = '0;
  assign mem_awqos_o   = '0;
  assign mem_wdata_o   = pkt_tdata_i;
  assign mem_arvalid_o = 1'b0;
  assign mem_rready_o  = 1'b0;
  assign unused_ok     = ^{pkt_tkeep_i, mem_bresp_i};

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    beats_left_d  = beats_left_q;
    rem_d         = rem_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_tready_o  = 1'b0;
    mem_awvalid_o = 1'b0;
    mem_wvalid_o  = 1'b0;
    mem_wlast_o   = 1'b0;
    mem_wstrb_o   = '1;
    mem_bready_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_tvalid_i) begin
          cur_addr_d   = addr_i;
          rem_d        = pkt_size_i[SIZE_LOG2-1:0];
          beats_left_d = beats_in;
          beat_cnt_d   = '0;
          // A zero-length packet skips AW and is drained in DATA.
          state_d      = (beats_in == '0) ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: begin
        mem_awvalid_o = 1'b1;
        if (mem_awready_i) begin
          len_d   = len_now;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beats_left_q == '0) begin
          pkt_tready_o = 1'b1;
          if (pkt_tvalid_i && pkt_tlast_i) state_d = S_IDLE;
        end else begin
          pkt_tready_o = mem_wready_i;
          mem_wvalid_o = pkt_tvalid_i;
          mem_wlast_o  = burst_end;
          if (beats_left_q == SIZE_W'(1) && rem_q != '0) mem_wstrb_o = strb_last;
          if (pkt_tvalid_i && mem_wready_i) begin
            beats_left_d = beats_left_q - SIZE_W'(1);
            beat_cnt_d   = beat_cnt_q + 9'd1;
            if (burst_end) begin
              cur_addr_d = cur_addr_q + (ADDR_WIDTH'(len_q) << SIZE_LOG2);
              beat_cnt_d = '0;
              state_d    = S_RESP;
            end
          end
        end
      end
      S_RESP: begin
        mem_bready_o = 1'b1;
        if (mem_bvalid_i) state_d = (beats_left_q != '0) ? S_ADDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rem_q        <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rem_q        <= rem_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_to_axi4_burst_writer.sv
// Directed bench for axis_to_axi4_burst_writer: acts as stream source and AXI4 write slave.
module tb_axis_to_axi4_burst_writer;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] pkt_size;
  logic [AW-1:0] addr;
  logic [DW-1:0] tdata;
  logic [7:0]    tkeep;
  logic          tvalid, tlast, tready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst, bresp;
  logic [3:0]    awid, awcache, awqos;
  logic          awlock, awvalid, awready;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic          bvalid, bready, arvalid, rready;

  int passed = 0, total = 0, fails = 0;

  logic [31:0] exp_aw_addr [4];
  int          exp_aw_len  [4];
  int          exp_naw;
  logic [7:0]  exp_last_strb;
  int          aw_hold, b_hold;

  always #5 clk = ~clk;

  axis_to_axi4_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_SIZE_B(9600)) dut (
    .clk_i(clk), .rst_i(rst_n), .pkt_size_i(pkt_size), .addr_i(addr),
    .pkt_tdata_i(tdata), .pkt_tkeep_i(tkeep), .pkt_tvalid_i(tvalid), .pkt_tlast_i(tlast),
    .pkt_tready_o(tready),
    .mem_awaddr_o(awaddr), .mem_awlen_o(awlen), .mem_awsize_o(awsize), .mem_awburst_o(awburst),
    .mem_awid_o(awid), .mem_awlock_o(awlock), .mem_awcache_o(awcache), .mem_awprot_o(awprot),
    .mem_awqos_o(awqos), .mem_awvalid_o(awvalid), .mem_awready_i(awready),
    .mem_wdata_o(wdata), .mem_wstrb_o(wstrb), .mem_wlast_o(wlast), .mem_wvalid_o(wvalid),
    .mem_wready_i(wready), .mem_bresp_i(bresp), .mem_bvalid_i(bvalid), .mem_bready_o(bready),
    .mem_arvalid_o(arvalid), .mem_rready_o(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int tag, input int beat);
    return {16'(tag), 16'hC0DE, 32'(beat)};
  endfunction

  task automatic set_exp(input int n, input logic [31:0] a0, input int l0,
                         input logic [31:0] a1, input int l1, input logic [7:0] strb);
    exp_naw = n;
    exp_aw_addr[0] = a0; exp_aw_len[0] = l0;
    exp_aw_addr[1] = a1; exp_aw_len[1] = l1;
    exp_last_strb = strb;
  endtask

  // One packet: stream source with random tvalid, AXI4 slave with random ready/response timing.
  task automatic run_pkt(input string name, input logic [31:0] a, input logic [SW-1:0] sz,
                         input int nbeats, input int tv_pct, input int wr_pct, input int tag);
    int sent = 0, aw_idx = 0, b_cnt = 0, wb = 0, wk = 0, wbeat = 0, cyc = 0, first_tv = -1;
    int aw_stall = 0, b_stall = 0;
    bit pending_b = 0, tv_hold = 0, aw_seen = 0;
    int total_beats = (int'(sz) + 7) / 8;
    addr = a;
    pkt_size = sz;
    while (!(sent == nbeats && b_cnt == exp_naw && !pending_b)) begin
      @(negedge clk);
      if (cyc > 3000) begin
        check({name, "_timeout"}, 64'd1, 64'd0);
        break;
      end
      cyc++;
      if (!tv_hold) tvalid = (sent < nbeats) && ($urandom_range(99) < tv_pct);
      tdata   = mk_data(tag, sent);
      tlast   = (sent == nbeats - 1);
      wready  = ($urandom_range(99) < wr_pct);
      awready = (aw_stall >= aw_hold) && ($urandom_range(99) < 70);
      bvalid  = pending_b && (b_stall >= b_hold) && ($urandom_range(99) < 60);
      #1;
      if (tvalid && first_tv < 0) begin
        first_tv = cyc;
        check({name, "_idle_tready"}, 64'(tready), 64'd0);
      end
      if (awvalid && !aw_seen) begin
        aw_seen = 1;
        check({name, "_aw_latency"}, 64'(cyc - first_tv), 64'd1);
      end
      if (pending_b) check({name, "_no_aw_before_b"}, 64'(awvalid), 64'd0);
      if (awvalid && !awready && aw_stall < aw_hold) begin
        aw_stall++;
        check({name, "_stall_tready"}, 64'(tready), 64'd0);
        check({name, "_stall_awaddr"}, 64'(awaddr), 64'(exp_aw_addr[0]));
        check({name, "_stall_awlen"}, 64'(awlen), 64'(exp_aw_len[0]));
      end
      if (pending_b && b_stall < b_hold) b_stall++;
      if (awvalid && awready) begin
        if (aw_idx < exp_naw) begin
          check({name, "_awaddr"}, 64'(awaddr), 64'(exp_aw_addr[aw_idx]));
          check({name, "_awlen"}, 64'(awlen), 64'(exp_aw_len[aw_idx]));
          check({name, "_awsize_burst"}, {59'd0, awsize, awburst}, {59'd0, 3'd3, 2'd1});
        end else check({name, "_extra_aw"}, 64'd1, 64'd0);
        aw_idx++;
      end
      if (wvalid && wready) begin
        if (wbeat >= total_beats || wb >= exp_naw) check({name, "_extra_w"}, 64'd1, 64'd0);
        else begin
          check({name, "_wdata"}, wdata, mk_data(tag, wbeat));
          check({name, "_wstrb"}, 64'(wstrb), (wbeat == total_beats - 1) ? 64'(exp_last_strb) : 64'hFF);
          check({name, "_wlast"}, 64'(wlast), 64'(wk == exp_aw_len[wb]));
          check({name, "_tready_follows_wready"}, 64'(tready), 64'd1);
          if (wk == exp_aw_len[wb]) begin
            wk = 0;
            wb++;
            pending_b = 1;
          end else wk++;
        end
        wbeat++;
      end
      if (bvalid && bready) begin
        pending_b = 0;
        b_cnt++;
      end
      if (tvalid && tready) begin
        sent++;
        tv_hold = 0;
      end else tv_hold = tvalid;
    end
    check({name, "_aw_count"}, 64'(aw_idx), 64'(exp_naw));
    check({name, "_w_count"}, 64'(wbeat), 64'(total_beats));
    aw_hold = 0;
    b_hold  = 0;
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = 8'hFF;
    addr = '0; pkt_size = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    aw_hold = 0; b_hold = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {58'd0, awvalid, wvalid, wlast, bready, tready, arvalid},  64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_exp(1, 32'h100, 0, 32'h0, 0, 8'hFF);
    run_pkt("single", 32'h100, 14'd8, 1, 100, 100, 1);

    set_exp(2, 32'h000FB100, 255, 32'h000FB900, 0, 8'h01);
    run_pkt("split_257", 32'h000FB100, 14'd2049, 257, 60, 60, 2);

    set_exp(2, 32'hFF0, 1, 32'h1000, 5, 8'hFF);
    run_pkt("cross_4k", 32'hFF0, 14'd64, 8, 70, 70, 3);

    set_exp(1, 32'h2000, 255, 32'h0, 0, 8'hFF);
    run_pkt("full_256", 32'h2000, 14'd2048, 256, 100, 100, 4);
    set_exp(1, 32'h3000, 1, 32'h0, 0, 8'hFF);
    run_pkt("back2back", 32'h3000, 14'd16, 2, 100, 100, 5);

    set_exp(2, 32'h4FF8, 0, 32'h5000, 2, 8'hFF);
    aw_hold = 20; b_hold = 15;
    run_pkt("backpressure", 32'h4FF8, 14'd32, 4, 80, 80, 6);

    set_exp(0, 32'h0, 0, 32'h0, 0, 8'hFF);
    run_pkt("zero_size", 32'h6000, 14'd0, 2, 100, 100, 7);
    set_exp(1, 32'h7000, 0, 32'h0, 0, 8'h3F);
    run_pkt("after_zero", 32'h7000, 14'd6, 1, 100, 100, 8);

    // Reset in the middle of a burst.
    @(negedge clk);
    addr = 32'h8000; pkt_size = 14'd64; tvalid = 1'b1; tlast = 1'b0; tdata = mk_data(9, 0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_wvalid", 64'(wvalid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valids", {60'd0, awvalid, wvalid, tready, bready}, 64'd0);
    check("mid_reset_wlast", 64'(wlast), 64'd0);
    tvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    set_exp(1, 32'h9000, 3, 32'h0, 0, 8'h0F);
    run_pkt("after_reset", 32'h9000, 14'd28, 4, 80, 80, 10);

    @(negedge clk);
    tvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
